// File: rtl/adder_pipe_if.sv
// adder_pipe_if: input beat and result beat stream bundle for adder_pipe.
// master = stream source/sink side, slave = adder_pipe.
interface adder_pipe_if #(
    parameter int DATA_WIDTH = 4,
    parameter int LANES      = 2
);
    logic                            in_valid;
    logic                            in_ready;
    logic [1:0]                      in_mode;
    logic                            in_clear;
    logic [LANES*DATA_WIDTH-1:0]     A;
    logic [LANES*DATA_WIDTH-1:0]     B;
    logic                            out_valid;
    logic                            out_ready;
    logic [LANES*(DATA_WIDTH+1)-1:0] X;
    logic [LANES-1:0]                out_ovf;

    modport master (
        output in_valid, in_mode, in_clear, A, B, out_ready,
        input  in_ready, out_valid, X, out_ovf
    );

    modport slave (
        input  in_valid, in_mode, in_clear, A, B, out_ready,
        output in_ready, out_valid, X, out_ovf
    );
endinterface

// File: rtl/adder_pipe.sv
// adder_pipe: LANES-wide add/sub/accumulate with a STAGES-deep elastic
// pipeline and valid/ready backpressure on both sides.
// Optional build macro ADDER_PIPE_SAT_EN: saturating add/acc/sub instead of
// modular results.

// One lane: combinational result for the offered beat plus its accumulator.
module adder_pipe_lane #(
    parameter int DATA_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  accept,
    input  logic [1:0]            mode,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH:0]   res,
    output logic                  ovf
);
    localparam logic [1:0] MODE_SUB = 2'b01;
    localparam logic [1:0] MODE_ACC = 2'b10;
`ifdef ADDER_PIPE_SAT_EN
    localparam logic [DATA_WIDTH:0] SAT_MAX = {1'b0, {DATA_WIDTH{1'b1}}};
`endif

    logic [DATA_WIDTH:0] acc_d, acc_q;
    logic [DATA_WIDTH:0] acc_base, sum, diff, acc_sum;

    // Lane arithmetic; clear zeroes the accumulator before this beat's op
    always_comb begin
        acc_base = clear ? '0 : acc_q;
        sum      = {1'b0, a} + {1'b0, b};
        diff     = {1'b0, a} - {1'b0, b};
        acc_sum  = acc_base + {1'b0, a};
        res      = sum;
        ovf      = 1'b0;
`ifdef ADDER_PIPE_SAT_EN
        case (mode)
            MODE_SUB: begin
                res = diff[DATA_WIDTH] ? '0 : diff;
                ovf = diff[DATA_WIDTH];
            end
            MODE_ACC: begin
                // acc_base never exceeds SAT_MAX here, so acc_sum cannot wrap
                res = acc_sum[DATA_WIDTH] ? SAT_MAX : acc_sum;
                ovf = acc_sum[DATA_WIDTH];
            end
            default: begin
                res = sum[DATA_WIDTH] ? SAT_MAX : sum;
                ovf = sum[DATA_WIDTH];
            end
        endcase
`else
        case (mode)
            MODE_SUB: res = diff;
            MODE_ACC: res = acc_sum;
            default:  res = sum;
        endcase
        ovf = res[DATA_WIDTH];
`endif
        acc_d = acc_q;
        if (accept) begin
            acc_d = (mode == MODE_ACC) ? res : acc_base;
        end
    end

    // Accumulator only moves on an accepted beat
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end
endmodule

module adder_pipe #(
    parameter int DATA_WIDTH = 4,
    parameter int LANES      = 2,
    parameter int STAGES     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    adder_pipe_if.slave bus
);
    typedef struct packed {
        logic [LANES-1:0][DATA_WIDTH:0] res;
        logic [LANES-1:0]               ovf;
    } beat_t;

    logic [LANES-1:0][DATA_WIDTH-1:0] a_lane, b_lane;
    logic [LANES-1:0][DATA_WIDTH:0]   lane_res;
    logic [LANES-1:0]                 lane_ovf;
    beat_t                            in_beat;
    logic                             accept;
    logic [STAGES:1]                  vld_d, vld_q;
    logic [STAGES:0]                  vld_pipe;   // [0] is the offered input beat
    logic [STAGES:1]                  ld;
    beat_t                            stage_d [STAGES:1];
    beat_t                            stage_q [STAGES:1];

    assign a_lane        = bus.A;
    assign b_lane        = bus.B;
    assign vld_pipe      = {vld_q, bus.in_valid};
    assign accept        = bus.in_valid && ld[1];
    assign in_beat.res   = lane_res;
    assign in_beat.ovf   = lane_ovf;
    assign bus.in_ready  = ld[1];
    assign bus.out_valid = vld_pipe[STAGES];
    assign bus.X         = stage_q[STAGES].res;
    assign bus.out_ovf   = stage_q[STAGES].ovf;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        adder_pipe_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .accept (accept),
            .mode   (bus.in_mode),
            .clear  (bus.in_clear),
            .a      (a_lane[i]),
            .b      (b_lane[i]),
            .res    (lane_res[i]),
            .ovf    (lane_ovf[i])
        );
    end

    // Load enables: a stage loads when empty or when the stage ahead drains it
    always_comb begin
        ld         = '0;
        ld[STAGES] = !vld_q[STAGES] || bus.out_ready;
        for (int k = STAGES - 1; k >= 1; k--) begin
            ld[k] = !vld_q[k] || ld[k+1];
        end
    end

    // Next stage contents; data only moves with a valid beat so X holds when idle
    always_comb begin
        for (int k = 1; k <= STAGES; k++) begin
            vld_d[k]   = ld[k] ? vld_pipe[k-1] : vld_q[k];
            stage_d[k] = stage_q[k];
        end
        if (ld[1] && bus.in_valid) begin
            stage_d[1] = in_beat;
        end
        for (int k = 2; k <= STAGES; k++) begin
            if (ld[k] && vld_q[k-1]) begin
                stage_d[k] = stage_q[k-1];
            end
        end
    end

    // Pipeline registers; reset drops every in-flight beat
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int k = 1; k <= STAGES; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            for (int k = 1; k <= STAGES; k++) begin
                stage_q[k] <= stage_d[k];
            end
        end
    end
endmodule
